// File: rtl/mm_host_bridge.sv
// Host bridge for the Montgomery multiplier: loads p'0/p/a/b into the shared BRAM, starts the
// multiplier, then streams the result sections back out. `MM_BRIDGE_CYCLE_CNT_EN adds cycle_count_o.
module mm_host_bridge #(
  parameter int S            = 8,
  parameter int P_PRIME_ADDR = 0,
  parameter int P_BASE       = 1,
  parameter int A_BASE       = S + 1,
  parameter int B_BASE       = 2 * S + 1,
  parameter int RES_BASE     = S + 1,
  parameter int ADDR_W       = $clog2(4 * S)
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [16:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [16:0] m_tdata_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic [31:0] BRAM_addr_o,
  output logic [16:0] BRAM_din_o,
  input  logic [16:0] BRAM_dout_i,
  output logic        BRAM_we_o,
  output logic        BRAM_en_o,
  output logic        MM_start_o,
  input  logic        MM_done_i,
  output logic        busy_o
`ifdef MM_BRIDGE_CYCLE_CNT_EN
  ,
  output logic [31:0] cycle_count_o
`endif
);

  localparam int KW = $clog2(3 * S + 1);
  localparam int JW = $clog2(S + 1);
  localparam logic [KW-1:0] K_LAST = KW'(3 * S);
  localparam logic [JW-1:0] J_END  = JW'(S);
  localparam logic [JW-1:0] J_LAST = JW'(S - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_READ} state_t;

  state_t            state, state_nxt;
  logic              armed, load_rdy, in_hs, out_hs, fifo_valid, issue, in_flight;
  logic [KW-1:0]     k;
  logic [JW-1:0]     rd_idx, out_idx;
  logic [16:0]       fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic [16:0]       din_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr, addr_sel;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= ST_LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:  if (in_hs && k == K_LAST) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (MM_done_i) state_nxt = ST_READ;
      ST_READ:  if (out_hs && out_idx == J_LAST) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  assign load_rdy   = (state == ST_LOAD) && armed && !reset_i;
  assign in_hs      = s_tvalid_i && load_rdy;
  assign fifo_valid = (fifo_cnt != 2'd0);
  assign out_hs     = fifo_valid && m_tready_i;
  // Occupancy net of this cycle's pop, so a full-rate drain still issues one read per cycle.
  assign occ   = {1'b0, fifo_cnt} - {2'b0, out_hs} + {2'b0, in_flight};
  assign issue = (state == ST_READ) && !reset_i && (rd_idx != J_END) && (occ < 3'd2);

  always_comb begin
    if (k == '0)
      wr_addr = ADDR_W'(P_PRIME_ADDR);
    else if (k <= KW'(S))
      wr_addr = ADDR_W'(P_BASE) + ADDR_W'(k) - ADDR_W'(1);
    else if (k <= KW'(2 * S))
      wr_addr = ADDR_W'(A_BASE) + ADDR_W'(k) - ADDR_W'(S + 1);
    else
      wr_addr = ADDR_W'(B_BASE) + ADDR_W'(k) - ADDR_W'(2 * S + 1);
    rd_addr = ADDR_W'(RES_BASE) + ADDR_W'(rd_idx);
  end

  always_comb begin
    s_tready_o  = load_rdy;
    MM_start_o  = (state == ST_START);
    busy_o      = !((state == ST_LOAD) && (k == '0));
    BRAM_en_o   = in_hs || issue;
    BRAM_we_o   = in_hs;
    BRAM_din_o  = in_hs ? s_tdata_i : din_q;
    addr_sel    = in_hs ? wr_addr : (issue ? rd_addr : '0);
    BRAM_addr_o = {{(32 - ADDR_W){1'b0}}, addr_sel};
    m_tvalid_o  = fifo_valid;
    m_tdata_o   = fifo_valid ? fifo_mem[rd_ptr] : 17'd0;
    m_tlast_o   = fifo_valid && (out_idx == J_LAST);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      k         <= '0;
      rd_idx    <= '0;
      out_idx   <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      din_q     <= 17'd0;
    end else begin
      in_flight <= issue;
      fifo_cnt  <= fifo_cnt + {1'b0, in_flight} - {1'b0, out_hs};
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (in_hs) begin
        din_q <= s_tdata_i;
        k     <= (k == K_LAST) ? '0 : k + KW'(1);
      end
      if (issue) rd_idx <= rd_idx + JW'(1);
      if (out_hs) begin
        rd_ptr <= ~rd_ptr;
        if (out_idx == J_LAST) begin
          out_idx <= '0;
          rd_idx  <= '0;
        end else begin
          out_idx <= out_idx + JW'(1);
        end
      end
    end
  end

  // NOTE: skid storage is not reset; fifo_cnt and the pointers alone decide what is valid.
  always_ff @(posedge clock_i) begin
    if (in_flight) fifo_mem[wr_ptr] <= BRAM_dout_i;
  end

`ifdef MM_BRIDGE_CYCLE_CNT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i || state == ST_START)
      cycle_count_o <= 32'd0;
    else if (state == ST_WAIT && cycle_count_o != 32'hFFFF_FFFF)
      cycle_count_o <= cycle_count_o + 32'd1;
  end
`endif

endmodule
